zero2asic_arb: RTL

ZERO2ASIC_ARB -- requirements
Module: zero2asic_arb

---
 rtl/zero2asic_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/zero2asic_arb.sv
// Two-requester round-robin arbiter that loops each granted frame through a
// serial echo cell and returns the captured bits with an integrity flag.
module zero2asic_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic             link_rst,
    output logic             link_cs,
    output logic             link_din,
    input  logic             link_dout,
    output logic             busy
);

    localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   K_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic [CW-1:0]     k_q, k_d;

    logic              grant;
    logic              accept;
    logic [WIDTH-1:0]  cap_shift;

    // Grant selection and handshake outputs; gated by reset so no ready
    // can leak out while the block is held in reset.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end
        req0_ready = reset && (state_q == IDLE) && req0_valid && !grant;
        req1_ready = reset && (state_q == IDLE) && req1_valid &&  grant;
        accept     = req0_ready || req1_ready;

        rsp_valid  = (state_q == RESP);
        busy       = (state_q != IDLE);
        link_rst   = !reset || (state_q == CLEAR);
        link_cs    = (state_q == SHIFT);
        link_din   = (state_q == SHIFT) ? data_q[K_LAST - k_q] : 1'b0;
        rsp_data   = cap_q;
        rsp_id     = id_q;
        rsp_err    = err_q;
    end

    assign cap_shift = {cap_q[WIDTH-2:0], link_dout};

    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        err_d   = err_q;
        data_d  = data_q;
        cap_d   = cap_q;
        k_d     = k_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = grant ? req1_data : req0_data;
                    id_d    = grant;
                    last_d  = grant;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                k_d     = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                k_d = k_q + 1'b1;
                // The cell answers one cycle late, so the k=0 sample is stale.
                if (k_q != '0) begin
                    cap_d = cap_shift;
                end
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cap_d   = cap_shift;
                err_d   = (cap_shift != data_q);
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            cap_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            err_q   <= err_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            k_q     <= k_d;
        end
    end

endmodule
